// File: rtl/ysyx_22041071_fetch_req_pkg.sv
// Types and helpers shared by the fetch request unit and its pending queue.
package ysyx_22041071_fetch_req_pkg;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_B,
        REDIR_JAL,
        REDIR_JALR
    } redir_e;

    // PC bit choosing the upper or lower word of a 64-bit fetch beat
    localparam int INST_HI_BIT = 2;

    function automatic redir_e redir_pick(input logic b, input logic j, input logic jr);
        if (b)  return REDIR_B;
        if (j)  return REDIR_JAL;
        if (jr) return REDIR_JALR;
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/ysyx_22041071_define.sv
// Shared core-wide macros: bus widths, AXI encodings and the reset PC.
`ifndef YSYX_22041071_DEFINE_SV
`define YSYX_22041071_DEFINE_SV
`define ysyx_22041071_ADDR_BUS       64
`define ysyx_22041071_AXI_LEN_WIDTH  8
`define ysyx_22041071_SIZE_D         2'b11
`define ysyx_22041071_START_ADDR     64'h0000_0000_8000_0000
`endif

// File: rtl/ysyx_22041071_fetch_fifo.sv
// Pending-request queue: holds {pc, epoch} of each accepted AR until its last R beat.
module ysyx_22041071_fetch_fifo
    import ysyx_22041071_fetch_req_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 65,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22041071_fetch_req.sv
// Instruction fetch front end: issues AXI AR requests, tracks them in order and
// forwards returned words to decode, dropping beats made stale by a redirect.
`include "ysyx_22041071_define.sv"

module ysyx_22041071_fetch_req
    import ysyx_22041071_fetch_req_pkg::*;
#(
    parameter int                ADDR_W   = `ysyx_22041071_ADDR_BUS,
    parameter logic [ADDR_W-1:0] START_PC = `ysyx_22041071_START_ADDR,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    brch_sel,
    input  logic                                    jpc_sel,
    input  logic                                    jrpc_sel,
    input  logic [ADDR_W-1:0]                       bpc,
    input  logic [ADDR_W-1:0]                       jpc,
    input  logic [ADDR_W-1:0]                       jrpc,
    input  logic                                    stall,
    output logic                                    ar_valid,
    input  logic                                    ar_ready,
    output logic [ADDR_W-1:0]                       ar_addr,
    output logic [`ysyx_22041071_AXI_LEN_WIDTH-1:0] ar_len,
    output logic [1:0]                              ar_size,
    input  logic                                    r_valid,
    input  logic                                    r_last,
    input  logic [63:0]                             r_data,
    output logic                                    r_ready,
    output logic                                    inst_valid,
    input  logic                                    inst_ready,
    output logic [31:0]                             inst,
    output logic [ADDR_W-1:0]                       inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc, hold_addr, redir_pc, head_pc;
    logic              epoch, ar_hold, hold_stale, head_epoch;
    logic              redirect, ar_hs, issue_fresh, push_epoch, head_fresh, pop;
    logic              q_full, q_empty;
    logic [CW-1:0]     q_count;
    logic [ADDR_W:0]   head;
    redir_e            redir;

    always_comb begin
        redir    = redir_pick(brch_sel, jpc_sel, jrpc_sel);
        redir_pc = fetch_pc;
        unique case (redir)
            REDIR_B:    redir_pc = bpc;
            REDIR_JAL:  redir_pc = jpc;
            REDIR_JALR: redir_pc = jrpc;
            default:    redir_pc = fetch_pc;
        endcase
    end
    assign redirect = (redir != REDIR_NONE);

    // A presented AR stays put until accepted, even across redirects and stalls
    assign ar_valid = !reset && (ar_hold || (q_count < CW'(DEPTH) && !stall));
    assign ar_addr  = ar_hold ? hold_addr : fetch_pc;
    assign ar_len   = '0;
    assign ar_size  = `ysyx_22041071_SIZE_D;
    assign ar_hs    = ar_valid && ar_ready;

    // A held AR overtaken by a redirect is queued under the opposite epoch
    assign issue_fresh = !(ar_hold && hold_stale);
    assign push_epoch  = issue_fresh ? epoch : ~epoch;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= START_PC;
            epoch      <= 1'b0;
            ar_hold    <= 1'b0;
            hold_addr  <= START_PC;
            hold_stale <= 1'b0;
        end else begin
            ar_hold <= ar_valid && !ar_ready;
            if (ar_valid && !ar_ready) begin
                hold_addr  <= ar_addr;
                hold_stale <= (ar_hold && hold_stale) || redirect;
            end
            if (redirect) begin
                fetch_pc <= redir_pc;
                epoch    <= ~epoch;
            end else if (ar_hs && issue_fresh) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
            end
        end
    end

    ysyx_22041071_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ar_hs && !q_full),
        .push_data ({ar_addr, push_epoch}),
        .pop       (pop),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign head_pc    = head[ADDR_W:1];
    assign head_epoch = head[0];
    // Compared against the pre-update epoch so a beat landing with a redirect still goes out
    assign head_fresh = !q_empty && (head_epoch == epoch);

    assign inst_valid = !reset && r_valid && head_fresh;
    assign r_ready    = !reset && !q_empty && (head_fresh ? inst_ready : 1'b1);
    assign inst       = head_pc[INST_HI_BIT] ? r_data[63:32] : r_data[31:0];
    assign inst_pc    = head_pc;
    assign pop        = r_valid && r_ready && r_last;

endmodule

// File: tb/tb_ysyx_22041071_fetch_req.sv
// Directed bench: AXI slave model, expected AR/inst queues, negedge scoreboard monitor.
module tb_ysyx_22041071_fetch_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        brch_sel, jpc_sel, jrpc_sel;
    logic [63:0] bpc, jpc, jrpc;
    logic        stall;
    logic        ar_valid, ar_ready;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [1:0]  ar_size;
    logic        r_valid, r_last, r_ready;
    logic [63:0] r_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_ar[$];
    logic [63:0] exp_pc[$];
    logic [63:0] sq[$];
    logic [63:0] e_ar, e_pc;
    bit          r_hold = 1'b0;
    int          credit = 0;

    always #5 clk = ~clk;

    ysyx_22041071_fetch_req dut (
        .clk(clk), .reset(reset),
        .brch_sel(brch_sel), .jpc_sel(jpc_sel), .jrpc_sel(jrpc_sel),
        .bpc(bpc), .jpc(jpc), .jrpc(jrpc), .stall(stall),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size),
        .r_valid(r_valid), .r_last(r_last), .r_data(r_data), .r_ready(r_ready),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] beat_at(input logic [63:0] a);
        logic [63:0] b;
        b = {a[63:3], 3'b000};
        return {word_at(b + 64'd4), word_at(b)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: handshakes observed here complete at the following posedge
    always @(negedge clk) begin
        if (reset) begin
            sq.delete();
        end else begin
            if (ar_valid && ar_ready) begin
                if (exp_ar.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected got %h want none", ar_addr);
                end else begin
                    e_ar = exp_ar.pop_front();
                    chk("ar_addr", ar_addr, e_ar);
                    chk("ar_len_size", {54'd0, ar_len, ar_size}, {54'd0, 8'd0, 2'b11});
                end
                sq.push_back(ar_addr);
            end
            if (inst_valid && inst_ready) begin
                if (exp_pc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_unexpected got pc %h want none", inst_pc);
                end else begin
                    e_pc = exp_pc.pop_front();
                    chk("inst_pc", inst_pc, e_pc);
                    chk("inst", {32'd0, inst}, {32'd0, word_at(e_pc)});
                end
            end
            if (r_valid && r_ready) begin
                if (sq.size() > 0) void'(sq.pop_front());
                if (credit > 0) credit--;
            end
        end
    end

    // AXI read slave: one single-beat response per accepted AR, in order
    initial begin
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (sq.size() > 0 && (!r_hold || credit > 0)) begin
                r_valid = 1'b1;
                r_last  = 1'b1;
                r_data  = beat_at(sq[0]);
            end else begin
                r_valid = 1'b0;
                r_last  = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall = 1'b0;
        brch_sel = 1'b0; jpc_sel = 1'b0; jrpc_sel = 1'b0;
        bpc = '0; jpc = '0; jrpc = '0;
        ar_ready = 1'b1; inst_ready = 1'b1;
        tick(2);
        @(negedge clk);
        chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("rst_r_ready", {63'd0, r_ready}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);

        // sequential fetch straight out of reset
        exp_ar.push_back(64'h8000_0000); exp_ar.push_back(64'h8000_0004); exp_ar.push_back(64'h8000_0008);
        exp_pc.push_back(64'h8000_0000); exp_pc.push_back(64'h8000_0004); exp_pc.push_back(64'h8000_0008);
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("first_ar_valid", {63'd0, ar_valid}, 64'd1);
        chk("first_ar_addr", ar_addr, 64'h8000_0000);
        tick(3);
        stall = 1'b1;
        tick(8);
        chk("seq_drain", 64'(exp_ar.size() + exp_pc.size()), 64'd0);

        // decode backpressure on a fresh head at an upper-word PC
        jpc = 64'h8000_0004; jpc_sel = 1'b1;
        tick(1);
        jpc_sel = 1'b0; inst_ready = 1'b0; stall = 1'b0;
        exp_ar.push_back(64'h8000_0004);
        tick(1);
        stall = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
            chk("bp_r_ready", {63'd0, r_ready}, 64'd0);
            chk("bp_inst_hi", {32'd0, inst}, {32'd0, word_at(64'h8000_0004)});
            chk("bp_inst_pc", inst_pc, 64'h8000_0004);
            tick(1);
        end
        exp_pc.push_back(64'h8000_0004);
        inst_ready = 1'b1;
        tick(4);
        chk("bp_drain", 64'(exp_ar.size() + exp_pc.size()), 64'd0);

        // redirect while an AR is held unaccepted
        jrpc = 64'h8000_0000; jrpc_sel = 1'b1;
        tick(1);
        jrpc_sel = 1'b0; ar_ready = 1'b0; stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                jpc = 64'h8000_1000; jpc_sel = 1'b1;
            end else begin
                jpc_sel = 1'b0;
            end
            @(negedge clk);
            chk("hold_ar_valid", {63'd0, ar_valid}, 64'd1);
            chk("hold_ar_addr", ar_addr, 64'h8000_0000);
            tick(1);
        end
        exp_ar.push_back(64'h8000_0000); exp_ar.push_back(64'h8000_1000);
        exp_pc.push_back(64'h8000_1000);
        ar_ready = 1'b1;
        tick(1);
        @(negedge clk);
        chk("stale_r_ready", {63'd0, r_ready}, 64'd1);
        chk("stale_no_inst", {63'd0, inst_valid}, 64'd0);
        tick(1);
        stall = 1'b1;
        tick(6);
        chk("redir_drain", 64'(exp_ar.size() + exp_pc.size()), 64'd0);

        // branch beats jalr when both fire together
        bpc = 64'h8000_0100; brch_sel = 1'b1;
        jrpc = 64'h8000_0200; jrpc_sel = 1'b1;
        tick(1);
        brch_sel = 1'b0; jrpc_sel = 1'b0; stall = 1'b0;
        exp_ar.push_back(64'h8000_0100); exp_pc.push_back(64'h8000_0100);
        tick(1);
        stall = 1'b1;
        tick(5);
        chk("prio_drain", 64'(exp_ar.size() + exp_pc.size()), 64'd0);

        // queue full: AR stops at DEPTH, one returned beat reopens it
        r_hold = 1'b1; credit = 0; stall = 1'b0;
        exp_ar.push_back(64'h8000_0104); exp_ar.push_back(64'h8000_0108);
        exp_ar.push_back(64'h8000_010C); exp_ar.push_back(64'h8000_0110);
        tick(4);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("full_ar_off", {63'd0, ar_valid}, 64'd0);
            tick(1);
        end
        exp_ar.push_back(64'h8000_0114);
        exp_pc.push_back(64'h8000_0104); exp_pc.push_back(64'h8000_0108);
        exp_pc.push_back(64'h8000_010C); exp_pc.push_back(64'h8000_0110);
        exp_pc.push_back(64'h8000_0114);
        credit = 1;
        @(negedge clk);
        chk("full_beat_ar_off", {63'd0, ar_valid}, 64'd0);
        @(negedge clk);
        chk("full_reopen_valid", {63'd0, ar_valid}, 64'd1);
        chk("full_reopen_addr", ar_addr, 64'h8000_0114);
        tick(1);
        r_hold = 1'b0; stall = 1'b1;
        tick(10);
        chk("full_drain", 64'(exp_ar.size() + exp_pc.size()), 64'd0);

        // reset with three requests outstanding
        r_hold = 1'b1; credit = 0; stall = 1'b0;
        exp_ar.push_back(64'h8000_0118); exp_ar.push_back(64'h8000_011C); exp_ar.push_back(64'h8000_0120);
        tick(3);
        reset = 1'b1; stall = 1'b1;
        @(negedge clk);
        chk("mid_rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        tick(1);
        @(negedge clk);
        chk("post_rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("post_rst_r_ready", {63'd0, r_ready}, 64'd0);
        chk("post_rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        tick(1);
        r_hold = 1'b0; reset = 1'b0; stall = 1'b0;
        exp_ar.push_back(64'h8000_0000); exp_pc.push_back(64'h8000_0000);
        @(negedge clk);
        chk("rerun_ar_addr", ar_addr, 64'h8000_0000);
        tick(1);
        stall = 1'b1;
        tick(6);
        chk("final_drain", 64'(exp_ar.size() + exp_pc.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_fetch_req.md
YSYX_22041071_FETCH_REQ -- requirements
Module: ysyx_22041071_fetch_req

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  ADDR_W, 64, address/PC width
  START_PC, `START_ADDR, PC fetched first after reset
  DEPTH, 4, max outstanding AR requests (power of 2, >=2)
  PC_INC, 4, sequential PC increment
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  brch_sel / jpc_sel / jrpc_sel  in  1  redirect request, B / JAL / JALR
  bpc / jpc / jrpc  in  ADDR_W  matching redirect targets
  stall  in  1  inhibit new AR issue
  ar_valid  out  1  AXI AR valid
  ar_ready  in  1  AXI AR ready
  ar_addr  out  ADDR_W  fetch address
  ar_len  out  `ysyx_22041071_AXI_LEN_WIDTH  always 0
  ar_size  out  2  always `ysyx_22041071_SIZE_D
  r_valid / r_last  in  1  AXI R valid / last
  r_data  in  64  AXI R data
  r_ready  out  1  AXI R ready
  inst_valid  out  1  instruction to decode valid
  inst_ready  in  1  decode accepts
  inst  out  32  instruction word
  inst_pc  out  ADDR_W  PC of inst

Function
REQ-003 SHALL hold fetch_pc register = address of next AR to issue.
REQ-004 SHALL assert ar_valid when count<DEPTH and !stall, or while a presented AR is unaccepted.
REQ-005 SHALL keep ar_valid/ar_addr stable while ar_valid && !ar_ready (AXI rule), regardless of redirect or stall.
REQ-006 SHALL drive ar_addr = fetch_pc, ar_len = 0, ar_size = SIZE_D.
REQ-007 On AR handshake SHALL push {ar_addr, epoch} into the pending queue and set fetch_pc <= fetch_pc + PC_INC (mod 2^ADDR_W), unless redirected.
REQ-008 Redirect priority SHALL be brch_sel > jpc_sel > jrpc_sel; any asserted -> redirect.
REQ-009 On redirect: fetch_pc <= selected target, epoch toggles, all queued entries become stale; target issued on first cycle AR channel is free.
REQ-010 Redirect while an AR is pending unaccepted: AR held; once accepted it is queued with old epoch (stale); fetch_pc does not advance from it.
REQ-011 Redirect in same cycle as AR handshake: handshaken request is stale; fetch_pc <= target.
REQ-012 Queue head fresh iff head.epoch == current epoch register (pre-update value).
REQ-013 inst_valid = r_valid && queue non-empty && head fresh; inst = r_data[63:32] if head.pc[2] else r_data[31:0]; inst_pc = head.pc.
REQ-014 r_ready = inst_ready if head fresh, 1 if head stale (stale beats dropped silently).
REQ-015 Queue SHALL pop on r_valid && r_ready && r_last; count updates by push-pop (simultaneous push+pop -> unchanged).
REQ-016 Beat delivered in same cycle as a redirect SHALL still be delivered (older than redirect source).
REQ-017 Zero-latency paths: r->inst combinational; AR issue no later than cycle after queue slot frees.
REQ-018 r_valid with empty queue is a protocol error; SHALL be ignored (r_ready=0).

Reset
REQ-019 On reset: fetch_pc=START_PC, ar_valid=0, epoch=0, count=0, queue pointers 0, inst_valid=0, r_ready=0.
REQ-020 First AR (addr START_PC) SHALL be asserted in first cycle after reset deasserts.
REQ-021 Reset mid-operation SHALL discard all outstanding state; interconnect is reset together.

Structure
REQ-022 ADDR_BUS, AXI_LEN_WIDTH, SIZE_D, START_ADDR SHALL come from shared define.v; no local duplicates.
REQ-023 Pending queue SHALL be sub-module ysyx_22041071_fetch_fifo (DEPTH x {pc, epoch}, full/empty/count).

Verification
REQ-024 Reset release, ar_ready=1, R returns next cycle -> AR addrs 0x80000000, ...04, ...08; insts delivered in order with matching inst_pc.
REQ-025 ar_ready=0 for 5 cycles with jpc_sel pulse (jpc=0x80001000) -> ar_addr held 0x80000000; next AR 0x80001000; data of 0x80000000 dropped, inst_valid never for it.
REQ-026 brch_sel+jrpc_sel same cycle (bpc=0x80000100, jrpc=0x80000200) -> next AR 0x80000100.
REQ-027 R held off until DEPTH=4 ARs accepted -> ar_valid low with count=4; one R beat -> ar_valid reasserts next cycle.
REQ-028 inst_ready=0 with fresh head -> r_ready=0, inst stable; PC 0x80000004 -> inst = r_data[63:32].
REQ-029 reset asserted with 3 outstanding -> next cycle ar_valid=0, count=0; after release AR 0x80000000.
